// File: rtl/wb_ic_pkg.sv
// wb_ic_pkg: shared Wishbone interconnect types (select enum, request/response structs, port FSM states, burst-length width)
package wb_ic_pkg;
  localparam int WB_BL_W = 10;
  typedef enum logic [3:0] {
    SEL_NONE = 4'h0,
    SEL_B0   = 4'h1,
    SEL_B1   = 4'h2,
    SEL_H0   = 4'h3,
    SEL_B2   = 4'h4,
    SEL_B3   = 4'h8,
    SEL_H1   = 4'hC,
    SEL_W    = 4'hF
  } type_sel_e;
  typedef enum logic [1:0] {IDLE, ACT, DONE} state_e;
  typedef struct packed {
    logic [31:0]        dat;
    logic [31:0]        adr;
    logic [3:0]         sel;
    logic [WB_BL_W-1:0] bl;
    logic               bry;
    logic               we;
    logic [3:0]         tid;
  } type_wb_wr_intf;
  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        lack;
    logic        err;
  } type_wb_rd_intf;
endpackage

// File: rtl/wb_win_decode.sv
// wb_win_decode: combinational address-window decoder; in adr/stb/cyc, out hit and lowest matching window idx
module wb_win_decode #(
  parameter int           NWIN        = 4,
  parameter logic [7:0]   WIN_EN      = 8'h01,
  parameter logic [255:0] WIN_MASK    = {8{32'hFFFF_FFFF}},
  parameter logic [255:0] WIN_PATTERN = {8{32'hFFFF_FFFF}}
) (
  input  logic [31:0] adr,
  input  logic        stb,
  input  logic        cyc,
  output logic        hit,
  output logic [2:0]  idx
);
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = NWIN - 1; i >= 0; i--)
      if (WIN_EN[i] && stb && cyc && ((adr & WIN_MASK[32*i +: 32]) == WIN_PATTERN[32*i +: 32])) begin
        hit = 1'b1;
        idx = 3'(i);
      end
  end
endmodule

// File: rtl/wb_slave_port_nw.sv
// wb_slave_port_nw: windowed Wishbone slave port; master side m_wbd_*, downstream slave side s_wbd_*, hit_win_o, timeout_o
module wb_slave_port_nw
  import wb_ic_pkg::*;
#(
  parameter int           NWIN        = 4,
  parameter logic [7:0]   WIN_EN      = 8'h01,
  parameter logic [255:0] WIN_MASK    = {8{32'hFFFF_FFFF}},
  parameter logic [255:0] WIN_PATTERN = {8{32'hFFFF_FFFF}},
  parameter int           TO_W        = 8,
  parameter int           TO_CYCLES   = 200
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        m_wbd_dat_i,
  input  logic [31:0]        m_wbd_adr_i,
  input  logic [3:0]         m_wbd_sel_i,
  input  logic [WB_BL_W-1:0] m_wbd_bl_i,
  input  logic               m_wbd_bry_i,
  input  logic               m_wbd_we_i,
  input  logic               m_wbd_cyc_i,
  input  logic               m_wbd_stb_i,
  input  logic [3:0]         m_wbd_tid_i,
  output logic [31:0]        m_wbd_dat_o,
  output logic               m_wbd_ack_o,
  output logic               m_wbd_lack_o,
  output logic               m_wbd_err_o,
  output logic [31:0]        s_wbd_dat_o,
  output logic [31:0]        s_wbd_adr_o,
  output logic [3:0]         s_wbd_sel_o,
  output logic [WB_BL_W-1:0] s_wbd_bl_o,
  output logic               s_wbd_bry_o,
  output logic               s_wbd_we_o,
  output logic               s_wbd_cyc_o,
  output logic               s_wbd_stb_o,
  output logic [3:0]         s_wbd_tid_o,
  input  logic [31:0]        s_wbd_dat_i,
  input  logic               s_wbd_ack_i,
  input  logic               s_wbd_lack_i,
  input  logic               s_wbd_err_i,
  output logic [2:0]         hit_win_o,
  output logic               timeout_o
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  state_e               state_q, state_d;
  type_wb_wr_intf       wr_q, wr_d;
  type_wb_rd_intf       rd_q, rd_d;
  logic [WB_BL_W-1:0]   beats_q, beats_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [2:0]           hit_win_q, hit_win_d;
  logic                 stb_q, stb_d, to_q, to_d;
  logic                 hit;
  logic [2:0]           hit_idx;
  wb_win_decode #(
    .NWIN(NWIN), .WIN_EN(WIN_EN), .WIN_MASK(WIN_MASK), .WIN_PATTERN(WIN_PATTERN)
  ) u_dec (
    .adr(m_wbd_adr_i), .stb(m_wbd_stb_i), .cyc(m_wbd_cyc_i), .hit(hit), .idx(hit_idx)
  );
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    rd_d.ack  = 1'b0;
    rd_d.lack = 1'b0;
    rd_d.err  = 1'b0;
    beats_d   = beats_q;
    cnt_d     = cnt_q;
    hit_win_d = hit_win_q;
    stb_d     = stb_q;
    to_d      = 1'b0;
    case (state_q)
      IDLE:
        // a response still on the master bus means this strobe was already served
        if (hit && !(rd_q.ack || rd_q.lack || rd_q.err)) begin
          state_d   = ACT;
          stb_d     = 1'b1;
          wr_d.dat  = m_wbd_dat_i;
          wr_d.adr  = {m_wbd_adr_i[31:2], 2'b00};
          wr_d.sel  = m_wbd_sel_i;
          wr_d.bl   = m_wbd_bl_i;
          wr_d.bry  = m_wbd_bry_i;
          wr_d.we   = m_wbd_we_i;
          wr_d.tid  = m_wbd_tid_i;
          hit_win_d = hit_idx;
          beats_d   = (m_wbd_we_i || m_wbd_bl_i == '0) ? WB_BL_W'(1) : m_wbd_bl_i;
          cnt_d     = '0;
        end
      ACT:
        if (s_wbd_err_i) begin
          rd_d.err = 1'b1;
          state_d  = DONE;
          stb_d    = 1'b0;
        end else if (s_wbd_ack_i) begin
          rd_d.dat = s_wbd_dat_i;
          rd_d.ack = 1'b1;
          cnt_d    = '0;
          if (beats_q == WB_BL_W'(1) || s_wbd_lack_i) begin
            rd_d.lack = 1'b1;
            state_d   = DONE;
            stb_d     = 1'b0;
          end else
            beats_d = beats_q - WB_BL_W'(1);
        end else if (cnt_q == TO_LAST) begin
          rd_d.err = 1'b1;
          to_d     = 1'b1;
          state_d  = DONE;
          stb_d    = 1'b0;
        end else
          cnt_d = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      hit_win_q <= '0;
      stb_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      beats_q   <= beats_d;
      cnt_q     <= cnt_d;
      hit_win_q <= hit_win_d;
      stb_q     <= stb_d;
      to_q      <= to_d;
    end
  end
  assign m_wbd_dat_o  = rd_q.dat;
  assign m_wbd_ack_o  = rd_q.ack;
  assign m_wbd_lack_o = rd_q.lack;
  assign m_wbd_err_o  = rd_q.err;
  assign s_wbd_dat_o  = wr_q.dat;
  assign s_wbd_adr_o  = wr_q.adr;
  assign s_wbd_sel_o  = wr_q.sel;
  assign s_wbd_bl_o   = wr_q.bl;
  assign s_wbd_bry_o  = wr_q.bry;
  assign s_wbd_we_o   = wr_q.we;
  assign s_wbd_tid_o  = wr_q.tid;
  assign s_wbd_cyc_o  = stb_q;
  assign s_wbd_stb_o  = stb_q;
  assign hit_win_o    = hit_win_q;
  assign timeout_o    = to_q;
endmodule

// File: tb/tb_wb_slave_port_nw.sv
// tb_wb_slave_port_nw: directed stimulus with a response scoreboard for wb_slave_port_nw
module tb_wb_slave_port_nw;
  import wb_ic_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] m_dat = '0, m_adr = '0, s_dat = '0;
  logic [3:0]  m_sel = '0, m_tid = '0;
  logic [9:0]  m_bl = '0;
  logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
  logic        s_ack = 1'b0, s_lack = 1'b0, s_err = 1'b0;
  logic [31:0] m_dat_o, s_dat_o, s_adr_o;
  logic [3:0]  s_sel_o, s_tid_o;
  logic [9:0]  s_bl_o;
  logic        m_ack, m_lack, m_err, s_bry, s_we, s_cyc, s_stb, to_o;
  logic [2:0]  hit_win;
  int          total = 0, bad = 0;
  typedef struct {logic [31:0] dat; logic lack, err, to;} exp_t;
  exp_t q[$];
  exp_t e;
  wb_slave_port_nw #(
    .NWIN(4), .WIN_EN(8'h07),
    .WIN_MASK({128'h0, 32'h0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000}),
    .WIN_PATTERN({128'h0, 32'h0, 32'h3000_0000, 32'h1000_0000, 32'h1000_0000}),
    .TO_W(8), .TO_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_wbd_dat_i(m_dat), .m_wbd_adr_i(m_adr), .m_wbd_sel_i(m_sel), .m_wbd_bl_i(m_bl),
    .m_wbd_bry_i(1'b0), .m_wbd_we_i(m_we), .m_wbd_cyc_i(m_cyc), .m_wbd_stb_i(m_stb),
    .m_wbd_tid_i(m_tid), .m_wbd_dat_o(m_dat_o), .m_wbd_ack_o(m_ack), .m_wbd_lack_o(m_lack),
    .m_wbd_err_o(m_err), .s_wbd_dat_o(s_dat_o), .s_wbd_adr_o(s_adr_o), .s_wbd_sel_o(s_sel_o),
    .s_wbd_bl_o(s_bl_o), .s_wbd_bry_o(s_bry), .s_wbd_we_o(s_we), .s_wbd_cyc_o(s_cyc),
    .s_wbd_stb_o(s_stb), .s_wbd_tid_o(s_tid_o), .s_wbd_dat_i(s_dat), .s_wbd_ack_i(s_ack),
    .s_wbd_lack_i(s_lack), .s_wbd_err_i(s_err), .hit_win_o(hit_win), .timeout_o(to_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic w, input logic [9:0] bl);
    m_adr = a;
    m_we  = w;
    m_bl  = bl;
    m_dat = 32'hC0DE_0000 ^ a;
    m_sel = 4'hF;
    m_tid = 4'h3;
    m_stb = 1'b1;
    m_cyc = 1'b1;
  endtask
  task automatic drop;
    m_stb = 1'b0;
    m_cyc = 1'b0;
  endtask
  task automatic push(input logic [31:0] d, input logic l, input logic er, input logic t);
    exp_t x;
    x.dat = d;
    x.lack = l;
    x.err = er;
    x.to = t;
    q.push_back(x);
  endtask
  task automatic rd1(input logic [31:0] a, input logic [31:0] d);
    req(a, 1'b0, 10'd1);
    push(d, 1'b1, 1'b0, 1'b0);
    tick;
    tick;
    s_ack = 1'b1;
    s_dat = d;
    tick;
    s_ack = 1'b0;
    drop;
    tick;
  endtask
  always @(negedge clk) begin
    if (m_ack || m_err || m_lack) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got ack=%b lack=%b err=%b expected none", m_ack, m_lack, m_err);
      end else begin
        e = q.pop_front();
        chk("resp_ack", 32'(m_ack), 32'(!e.err));
        chk("resp_err", 32'(m_err), 32'(e.err));
        chk("resp_lack", 32'(m_lack), 32'(e.lack));
        chk("resp_timeout", 32'(to_o), 32'(e.to));
        if (!e.err) chk("resp_dat", m_dat_o, e.dat);
      end
    end
  end
  initial begin
    int n;
    logic seen;
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic seen;
    tick;
    tick;
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_cyc", 32'(s_cyc), 0);
    chk("rst_adr", s_adr_o, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_hit", 32'(hit_win), 0);
    rst = 1'b0;
    tick;
    req(32'h3000_0013, 1'b0, 10'd1);
    push(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    tick;
    chk("t1_stb", 32'(s_stb), 1);
    chk("t1_adr", s_adr_o, 32'h3000_0010);
    chk("t1_hit", 32'(hit_win), 2);
    tick;
    chk("t1_ack_early", 32'(m_ack), 0);
    s_ack = 1'b1;
    s_dat = 32'hDEAD_BEEF;
    tick;
    s_ack = 1'b0;
    chk("t1_ack", 32'(m_ack), 1);
    chk("t1_lack", 32'(m_lack), 1);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("t1_cyc_low", 32'(s_cyc), 0);
    drop;
    tick;
    req(32'h1000_0000, 1'b0, 10'd1);
    tick;
    chk("t2_hit_lowest", 32'(hit_win), 0);
    drop;
    tick;
    s_ack = 1'b1;
    s_dat = 32'h1111_1111;
    push(32'h1111_1111, 1'b1, 1'b0, 1'b0);
    tick;
    s_ack = 1'b0;
    tick;
    req(32'h5000_0000, 1'b0, 10'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (s_cyc) seen = 1'b1;
    end
    chk("t2_miss_cyc", 32'(seen), 0);
    drop;
    tick;
    req(32'h3000_0004, 1'b0, 10'd4);
    for (int i = 1; i <= 4; i++) push(32'(i), i == 4, 1'b0, 1'b0);
    tick;
    for (int i = 1; i <= 4; i++) begin
      tick;
      s_ack = 1'b1;
      s_dat = 32'(i);
      s_lack = (i == 4);
    end
    tick;
    s_ack = 1'b0;
    s_lack = 1'b0;
    chk("t3_cyc_low", 32'(s_cyc), 0);
    chk("t3_lack", 32'(m_lack), 1);
    tick;
    chk("t3_no_recapture", 32'(s_cyc), 0);
    drop;
    tick;
    chk("t3_idle", 32'(s_cyc), 0);
    req(32'h3000_0020, 1'b1, 10'd3);
    push(32'h0, 1'b1, 1'b0, 1'b0);
    tick;
    chk("wr_we", 32'(s_we), 1);
    chk("wr_dat", s_dat_o, 32'hF0DE_0020);
    chk("wr_bl", 32'(s_bl_o), 3);
    tick;
    s_ack = 1'b1;
    s_dat = 32'h0;
    tick;
    s_ack = 1'b0;
    drop;
    tick;
    req(32'h3000_0008, 1'b0, 10'd1);
    push(32'h0, 1'b0, 1'b1, 1'b1);
    tick;
    n = 1;
    while (!m_err && n < 40) begin
      tick;
      n++;
    end
    chk("t4_to_cycle", 32'(n), 17);
    chk("t4_to_pulse", 32'(to_o), 1);
    chk("t4_cyc_low", 32'(s_cyc), 0);
    drop;
    tick;
    rd1(32'h3000_000C, 32'h0000_5A5A);
    req(32'h3000_0010, 1'b0, 10'd1);
    push(32'h0, 1'b0, 1'b1, 1'b0);
    tick;
    tick;
    s_ack = 1'b1;
    s_err = 1'b1;
    s_dat = 32'h7777_7777;
    tick;
    s_ack = 1'b0;
    s_err = 1'b0;
    chk("t5_err", 32'(m_err), 1);
    chk("t5_ack", 32'(m_ack), 0);
    drop;
    tick;
    req(32'h3000_0000, 1'b0, 10'd4);
    push(32'hA1, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    s_ack = 1'b1;
    s_dat = 32'hA1;
    tick;
    s_dat = 32'hA2;
    rst = 1'b1;
    tick;
    chk("t6_ack", 32'(m_ack), 0);
    chk("t6_lack", 32'(m_lack), 0);
    chk("t6_err", 32'(m_err), 0);
    chk("t6_dat", m_dat_o, 0);
    chk("t6_cyc", 32'(s_cyc), 0);
    chk("t6_stb", 32'(s_stb), 0);
    chk("t6_adr", s_adr_o, 0);
    chk("t6_hit", 32'(hit_win), 0);
    chk("t6_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    s_ack = 1'b0;
    drop;
    tick;
    rd1(32'h3000_0044, 32'h600D_F00D);
    tick;
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_slave_port_nw.md
# wb_slave_port_nw

Parametrised Wishbone slave port for the interconnect. It decodes a master request against up to eight address windows, then captures the matching request into a staging register. It drives one downstream slave, returns registered ack, last-ack and err to the master, and supports read bursts. A timeout counter turns a hung slave into a master error.

## Interface
- NWIN, 4: number of address windows, 1..8.
- WIN_EN, 8'h01: bit i enables window i.
- WIN_MASK, {8{32'hFFFF_FFFF}}: packed 8×32; window i is `WIN_MASK[32*i +: 32]`.
- WIN_PATTERN, {8{32'hFFFF_FFFF}}: packed 8×32; window i matches when `(adr & mask) == pattern`.
- TO_W, 8: timeout counter width.
- TO_CYCLES, 200: cycles without slave ack/err before abort; range 1..2^TO_W−1.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_wbd_dat_i, m_wbd_adr_i  in  32  master write data and byte address.
- m_wbd_sel_i  in  4  byte selects.
- m_wbd_bl_i  in  10  burst length in beats; 0 is treated as 1.
- m_wbd_bry_i, m_wbd_we_i, m_wbd_cyc_i, m_wbd_stb_i  in  1  burst-ready, write, cycle, strobe.
- m_wbd_tid_i  in  4  target id.
- m_wbd_dat_o  out  32  read data.
- m_wbd_ack_o, m_wbd_lack_o, m_wbd_err_o  out  1  beat ack, last-beat ack, error.
- s_wbd_dat_o, s_wbd_adr_o  out  32  staged write data and word address ([1:0]=0).
- s_wbd_sel_o  out  4; s_wbd_bl_o  out  10; s_wbd_tid_o  out  4.
- s_wbd_bry_o, s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o  out  1.
- s_wbd_dat_i  in  32; s_wbd_ack_i, s_wbd_lack_i, s_wbd_err_i  in  1.
- hit_win_o  out  3  index of the window that was captured.
- timeout_o  out  1  one-cycle pulse on abort.

## Operation
- **Decode.** A window is hit when `WIN_EN[i] & m_stb & m_cyc & ((m_adr & mask_i) == pattern_i)`. The lowest index wins. A miss is silent: other ports own those addresses.
- **FSM states:**
  - IDLE → ACT on hit, provided no m_ack/m_lack/m_err is being driven this cycle. This rule stops a request whose ack is already in flight from being captured a second time. On capture, latch adr[31:2]&2'b00, dat, sel, we, bry, tid and hit index. Beat counter `beats = (bl==0) ? 1 : bl`; writes force `beats = 1`.
  - ACT: s_cyc/s_stb held high. On each s_ack:
    - register s_dat_i into m_dat_o;
    - if `beats==1` or s_lack, pulse m_ack and m_lack next cycle and go to DONE;
    - otherwise pulse m_ack only and decrement beats.
  - ACT on s_err: m_err next cycle, go to DONE.
  - ACT on timeout (count == TO_CYCLES−1 with no s_ack/s_err): m_err and timeout_o next cycle, go to DONE.
  - DONE, one cycle: s_cyc/s_stb low, capture blocked; then → IDLE.
- **Timeout counter.** Clears on entering ACT and on every s_ack. Saturates; never wraps.
- **Priority within a cycle:** s_err > s_ack > timeout.
- **Write bursts.** Not supported; a write with bl>1 completes as one beat with m_lack asserted.
- **Reset.** rst_i at any time, including mid-burst, forces IDLE at the next edge. All outputs go to 0: m_dat_o=0, s_adr_o=0, hit_win_o=0, s_cyc_o/s_stb_o=0.

## Timing
- **Request:** hit seen in cycle t → s_cyc/s_stb high from t+1.
- **Response:** s_ack in cycle t → m_ack_o and m_dat_o valid in t+1. On the last beat, s_cyc/s_stb are low in t+1.
- **Minimum single-beat round trip:** 3 cycles from master strobe to m_ack_o, given a zero-wait slave.
- **Throughput:** back-to-back requests need one idle cycle, because DONE blocks the cycle after the final ack. Read bursts run at one beat per cycle if the slave acks every cycle.
- **Output timing:** all m_* and s_* outputs come directly from flops; there is no combinational path from input to output.

## Structure
- **Package `wb_ic_pkg`** holds:
  - `type_sel_e`;
  - `type_wb_wr_intf` and `type_wb_rd_intf`;
  - the FSM enum `{IDLE, ACT, DONE}`;
  - the constant `WB_BL_W = 10`.
- **Sub-module `wb_win_decode`** (combinational): inputs NWIN, WIN_EN, WIN_MASK, WIN_PATTERN, adr, stb, cyc; outputs hit and idx[2:0]. It is reused by the next-generation master arbiter.

## Test plan
1. Window 2 enabled (mask FFFF_0000, pattern 3000_0000); read adr 3000_0013, bl=1, zero-wait slave returns DEAD_BEEF → s_adr_o=3000_0010, s_stb_o high from t+1, m_ack_o=m_lack_o=1 with m_dat_o=DEAD_BEEF at t+3, hit_win_o=2.
2. Windows 0 and 1 both match adr 1000_0000 → hit_win_o=0. Adr 5000_0000 matches no window → s_cyc_o stays 0 for 20 cycles.
3. Read burst bl=4, slave acks on 4 consecutive cycles with data 1..4, s_lack on the 4th → four m_ack pulses carrying 1..4, m_lack only on the 4th, s_cyc_o low the cycle after, and the master's held stb is not re-captured.
4. TO_CYCLES=16, slave never acks → m_err_o and timeout_o pulse on cycle 17 after s_stb rises, s_cyc_o drops, and the next request is accepted normally.
5. s_err and s_ack asserted in the same cycle → m_err_o=1 and m_ack_o=0.
6. rst_i asserted during beat 2 of a 4-beat burst → the next edge shows every output at 0 and state IDLE; a fresh request after reset completes normally.
